registro_pipeline: RTL and testbench
====================================

# registro_pipeline

Parametrised successor to the plain N-bit capture register. It is a DEPTH-stage, WIDTH-bit pipeline register with a per-stage valid bit and valid/ready flow control. Bubbles collapse under backpressure, and a synchronous flush is provided. It sits between datapath blocks that need registered boundaries without losing throughput when the consumer stalls.

## Interface
- WIDTH, 32: data width in bits, ≥1.
- DEPTH, 2: number of register stages, ≥1; DEPTH=1 is a single handshaked register.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- flush  in  1  synchronous clear of all stage valid bits.
- in_valid  in  1  producer presents in_data.
- in_ready  out  1  pipeline accepts in_data this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WIDTH  output word.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages; present only with REGISTRO_PIPELINE_OCC_EN.

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side):
  - data_q[i] (WIDTH bits).
  - valid_q[i] (1 bit).
- Ready chain, combinational:
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !valid_q[i] || rdy[i+1].
- Stage update: when rdy[i]=1 and flush=0, stage i loads from its source.
  - Source for stage 0: in_valid/in_data.
  - Source for stage i>0: valid_q[i-1]/data_q[i-1].
  - valid_q[i] takes the source valid; data_q[i] loads only when the source valid is 1.
- Holding: a stage with rdy[i]=0 holds both data and valid.
- Outputs and transfers:
  - in_ready = rdy[0] && !flush.
  - out_valid = valid_q[DEPTH-1]; out_data = data_q[DEPTH-1].
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Ordering: words exit in arrival order; none is duplicated or dropped except by flush.
- Flush: all valid_q cleared next edge; data_q unchanged.
  - An output transfer in the same cycle completes; the consumer owns that word.
  - in_ready is 0 while flush=1, so no input transfer occurs.
- Reset (reset_n=0 at an edge): all valid_q=0 and all data_q=0, regardless of flush or handshakes.
  - Reset mid-operation discards every in-flight word.
- Protocol requirement: the producer holds in_data stable while in_valid && !in_ready. The block does not check this.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0. in_ready=1 once reset_n=1 and flush=0.
- Latency: a word accepted at edge k appears on out_valid/out_data after edge k+DEPTH-1, provided no stall occurs.
  - DEPTH=1: visible in the cycle after acceptance.
- Throughput: one word per cycle with out_ready held at 1.
- Full: all valid_q=1 and out_ready=0 gives in_ready=0.
- Simultaneous events when full:
  - out_ready=1 gives in_ready=1 the same cycle.
  - The input word and the output transfer both occur on one edge, and the pipeline stays full.
- Bubble collapse: with out_ready=0, an empty stage still accepts from its predecessor. Words compact toward the output.
- Combinational paths: the in_ready path from out_ready spans DEPTH stages. out_valid/out_data are purely registered.

## Configuration
- REGISTRO_PIPELINE_OCC_EN defined:
  - Adds the occupancy port = popcount(valid_q), combinational from registered state.
  - occupancy ranges 0..DEPTH, is 0 in the cycle after reset or flush, and never exceeds DEPTH.
- REGISTRO_PIPELINE_OCC_EN undefined: the port and popcount logic are absent; all other behaviour is identical.

## Structure
- Shared package registro_pkg:
  - Default constants REGISTRO_WIDTH_DEF=32 and REGISTRO_DEPTH_DEF=2.
  - Function occ_width(depth) returning $clog2(depth+1).
- Sub-module registro_etapa: one stage (data, valid, ready-out). Ports: clock, reset_n, flush, src_valid, src_data, dst_ready, valid_q, data_q, rdy.
- Top level generates DEPTH instances of registro_etapa and the optional popcount.

## Test plan
- Reset: hold reset_n=0 two cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=0, occupancy=0 after release.
- Streaming, DEPTH=3, out_ready=1: send 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on consecutive cycles; first word 2 cycles after its acceptance edge.
- Backpressure, DEPTH=3, out_ready=0:
  - Send 10,11,12,13 -> only 10,11,12 accepted; in_ready=0 on the fourth; occupancy=3.
  - Raise out_ready -> 10,11,12,13 delivered in order, no loss.
- Full with simultaneous transfer: pipeline full, out_ready=1 and in_valid=1 with in_data=99 -> same-edge transfer both sides; occupancy stays 3; 99 exits last.
- Flush: occupancy=2 with out_ready=1 and flush=1 -> current output word counted as delivered; next cycle out_valid=0, occupancy=0; in_ready=0 during the flush cycle.
- DEPTH=1, WIDTH=8: alternate out_ready 1/0 over bytes 8'hA5, 8'h5A -> each word held while out_ready=0 and delivered exactly once.

Source files
------------

// File: rtl/registro_pkg.sv
// Shared constants and helpers for the registro_pipeline slice.
// The optional occupancy port is enabled by REGISTRO_PIPELINE_OCC_EN.
package registro_pkg;

    localparam int REGISTRO_WIDTH_DEF = 32;
    localparam int REGISTRO_DEPTH_DEF = 2;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/registro_etapa.sv
// One pipeline stage: holds a word plus its valid bit and produces the
// ready signal its predecessor sees (ready when empty or when downstream drains).
module registro_etapa
    import registro_pkg::*;
#(
    parameter int WIDTH = REGISTRO_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             dst_ready,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output logic             rdy
);

    assign rdy = !valid_q || dst_ready;

    // Flush drops the valid bit only; the data register keeps its contents.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (rdy) begin
            valid_q <= src_valid;
            if (src_valid) begin
                data_q <= src_data;
            end
        end
    end

endmodule

// File: rtl/registro_pipeline.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse and flush.
// Define REGISTRO_PIPELINE_OCC_EN to add the occupancy (valid-stage count) port.
module registro_pipeline
    import registro_pkg::*;
#(
    parameter int WIDTH = REGISTRO_WIDTH_DEF,
    parameter int DEPTH = REGISTRO_DEPTH_DEF
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef REGISTRO_PIPELINE_OCC_EN
    output logic [occ_width(DEPTH)-1:0] occupancy,
`endif
    output logic [WIDTH-1:0]            out_data
);

    logic [DEPTH-1:0] valid_vec;
    logic [WIDTH-1:0] data_arr [DEPTH];
    logic [DEPTH:0]   rdy_chain;

    // The ready chain runs from the consumer back to the producer, one hop per stage.
    assign rdy_chain[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_first
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_next
            assign src_valid = valid_vec[i-1];
            assign src_data  = data_arr[i-1];
        end

        registro_etapa #(
            .WIDTH(WIDTH)
        ) u_etapa (
            .clock    (clock),
            .reset_n  (reset_n),
            .flush    (flush),
            .src_valid(src_valid),
            .src_data (src_data),
            .dst_ready(rdy_chain[i+1]),
            .valid_q  (valid_vec[i]),
            .data_q   (data_arr[i]),
            .rdy      (rdy_chain[i])
        );
    end

    assign in_ready  = rdy_chain[0] && !flush;
    assign out_valid = valid_vec[DEPTH-1];
    assign out_data  = data_arr[DEPTH-1];

`ifdef REGISTRO_PIPELINE_OCC_EN
    localparam int OW = occ_width(DEPTH);
    logic [OW-1:0] occ_sum;

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OW'(valid_vec[i]);
        end
    end

    assign occupancy = occ_sum;
`endif

endmodule

// File: tb/tb_registro_pipeline.sv
// Directed self-checking bench: a DEPTH=3/WIDTH=32 instance and a DEPTH=1/WIDTH=8 instance.
// Occupancy checks are active when REGISTRO_PIPELINE_OCC_EN is defined.
module tb_registro_pipeline;

    logic        clock;
    logic        reset_n;
    logic        a_flush;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_in_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [31:0] a_out_data;
    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_out_data;
`ifdef REGISTRO_PIPELINE_OCC_EN
    logic [1:0]  a_occ;
    logic [0:0]  b_occ;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    registro_pipeline #(.WIDTH(32), .DEPTH(3)) dut_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (a_flush),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .in_data  (a_in_data),
        .out_valid(a_out_valid),
        .out_ready(a_out_ready),
`ifdef REGISTRO_PIPELINE_OCC_EN
        .occupancy(a_occ),
`endif
        .out_data (a_out_data)
    );

    registro_pipeline #(.WIDTH(8), .DEPTH(1)) dut_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (b_flush),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
`ifdef REGISTRO_PIPELINE_OCC_EN
        .occupancy(b_occ),
`endif
        .out_data (b_out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let combinational outputs settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        a_flush     = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hDEADBEEF;
        a_out_ready = 1'b0;
        b_flush     = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 8'hEF;
        b_out_ready = 1'b0;
        step();
        step();

        reset_n    = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        settle();
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_out_data", a_out_data, 32'd0);
        check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        check("rst_b_out_data", 32'(b_out_data), 32'd0);
`ifdef REGISTRO_PIPELINE_OCC_EN
        check("rst_a_occ", 32'(a_occ), 32'd0);
`endif

        // Streaming with out_ready held high.
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 32'd1;
        step();
        a_in_data = 32'd2;
        step();
        check("stream_not_yet", 32'(a_out_valid), 32'd0);
        a_in_data = 32'd3;
        step();
        check("stream_w1_valid", 32'(a_out_valid), 32'd1);
        check("stream_w1", a_out_data, 32'd1);
        a_in_data = 32'd4;
        step();
        check("stream_w2", a_out_data, 32'd2);
        a_in_valid = 1'b0;
        step();
        check("stream_w3", a_out_data, 32'd3);
        step();
        check("stream_w4", a_out_data, 32'd4);
        check("stream_w4_valid", 32'(a_out_valid), 32'd1);
        step();
        check("stream_drained", 32'(a_out_valid), 32'd0);

        // Backpressure: fill three stages, fourth word refused.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'd10;
        settle();
        check("bp_rdy10", 32'(a_in_ready), 32'd1);
        step();
        a_in_data = 32'd11;
        settle();
        check("bp_rdy11", 32'(a_in_ready), 32'd1);
        step();
        a_in_data = 32'd12;
        settle();
        check("bp_rdy12", 32'(a_in_ready), 32'd1);
        step();
        a_in_data = 32'd13;
        settle();
        check("bp_full_rdy", 32'(a_in_ready), 32'd0);
        check("bp_head", a_out_data, 32'd10);
`ifdef REGISTRO_PIPELINE_OCC_EN
        check("bp_occ3", 32'(a_occ), 32'd3);
`endif
        step();
        check("bp_hold_head", a_out_data, 32'd10);
        check("bp_hold_rdy", 32'(a_in_ready), 32'd0);

        // Release: same-edge transfer on both sides while full.
        a_out_ready = 1'b1;
        settle();
        check("full_rdy_comb", 32'(a_in_ready), 32'd1);
        step();
        check("rel_w11", a_out_data, 32'd11);
`ifdef REGISTRO_PIPELINE_OCC_EN
        check("rel_occ3", 32'(a_occ), 32'd3);
`endif
        a_in_data = 32'd99;
        settle();
        check("sim_rdy", 32'(a_in_ready), 32'd1);
        step();
        check("sim_w12", a_out_data, 32'd12);
`ifdef REGISTRO_PIPELINE_OCC_EN
        check("sim_occ3", 32'(a_occ), 32'd3);
`endif
        a_in_valid = 1'b0;
        step();
        check("rel_w13", a_out_data, 32'd13);
        step();
        check("rel_w99", a_out_data, 32'd99);
        check("rel_w99_valid", 32'(a_out_valid), 32'd1);
        step();
        check("rel_empty", 32'(a_out_valid), 32'd0);

        // Flush with two words queued and an output transfer in the same cycle.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'd20;
        step();
        a_in_data = 32'd21;
        step();
        a_in_valid = 1'b0;
        step();
`ifdef REGISTRO_PIPELINE_OCC_EN
        check("fl_occ2", 32'(a_occ), 32'd2);
`endif
        check("fl_head", a_out_data, 32'd20);
        a_out_ready = 1'b1;
        a_flush     = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 32'd22;
        settle();
        check("fl_in_ready", 32'(a_in_ready), 32'd0);
        check("fl_out_valid_during", 32'(a_out_valid), 32'd1);
        step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        settle();
        check("fl_out_valid_after", 32'(a_out_valid), 32'd0);
        check("fl_data_kept", a_out_data, 32'd20);
        check("fl_rdy_after", 32'(a_in_ready), 32'd1);
`ifdef REGISTRO_PIPELINE_OCC_EN
        check("fl_occ0", 32'(a_occ), 32'd0);
`endif
        step();
        check("fl_no_input", 32'(a_out_valid), 32'd0);

        // DEPTH=1 single handshaked register.
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 8'hA5;
        settle();
        check("d1_rdy_empty", 32'(b_in_ready), 32'd1);
        step();
        check("d1_a5_valid", 32'(b_out_valid), 32'd1);
        check("d1_a5", 32'(b_out_data), 32'hA5);
        b_in_data = 8'h5A;
        settle();
        check("d1_full_rdy", 32'(b_in_ready), 32'd0);
        step();
        check("d1_a5_held", 32'(b_out_data), 32'hA5);
`ifdef REGISTRO_PIPELINE_OCC_EN
        check("d1_occ1", 32'(b_occ), 32'd1);
`endif
        b_out_ready = 1'b1;
        settle();
        check("d1_rdy_drain", 32'(b_in_ready), 32'd1);
        step();
        check("d1_5a", 32'(b_out_data), 32'h5A);
        b_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        step();
        check("d1_5a_held", 32'(b_out_data), 32'h5A);
        check("d1_5a_held_valid", 32'(b_out_valid), 32'd1);
        b_out_ready = 1'b1;
        step();
        check("d1_empty", 32'(b_out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
